// File: rtl/divider_pkg.sv
// Shared definitions for the divider and its front-end arbiter: default
// operand width and the arbiter FSM state encoding.
package divider_pkg;

  localparam int DIV_WIDTH = 32;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_ARM   = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_RESP  = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    ISSUE = ST_ISSUE,
    ARM   = ST_ARM,
    WAIT  = ST_WAIT,
    RESP  = ST_RESP
  } arb_state_t;

endpackage

// File: rtl/divider_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request after rr_ptr, wrapping,
// returned as a one-hot grant plus its index.
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               grant_valid
);

  int idx;

  // Offsets 1..NUM_REQ so the previous winner is checked last.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    idx         = 0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = (int'(rr_ptr) + off) % NUM_REQ;
      if (!grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant[idx]  = 1'b1;
        grant_idx   = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/divider_arbiter.sv
// Round-robin front end sharing one multi-cycle divider among NUM_REQ clients.
// Optional watchdog on the divider handshake is built with DIV_TIMEOUT_EN.
module divider_arbiter
  import divider_pkg::*;
#(
  parameter  int WIDTH   = DIV_WIDTH,
  parameter  int NUM_REQ = 4,
  parameter  int TIMEOUT = 2*WIDTH+8,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_dividend,
  input  logic [NUM_REQ*WIDTH-1:0] req_divisor,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [ID_W-1:0]          resp_id,
  output logic [WIDTH-1:0]         resp_quotient,
  output logic [WIDTH-1:0]         resp_remainder,
  output logic                     resp_error,
  output logic                     div_start,
  output logic [WIDTH-1:0]         div_dividend,
  output logic [WIDTH-1:0]         div_divisor,
  input  logic [WIDTH-1:0]         div_quotient,
  input  logic [WIDTH-1:0]         div_remainder,
  input  logic                     div_error,
  input  logic                     div_done,
  output logic                     busy
);

  arb_state_t          state;
  logic [ID_W-1:0]     rr_ptr;
  logic [NUM_REQ-1:0]  grant;
  logic [ID_W-1:0]     grant_idx;
  logic                grant_valid;
  logic [WIDTH-1:0]    sel_dividend;
  logic [WIDTH-1:0]    sel_divisor;

`ifdef DIV_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT+1);
  logic [CNT_W-1:0] wd_cnt;
`endif

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req         (req_valid),
    .rr_ptr      (rr_ptr),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  assign sel_dividend = req_dividend[int'(grant_idx)*WIDTH +: WIDTH];
  assign sel_divisor  = req_divisor[int'(grant_idx)*WIDTH +: WIDTH];
  assign req_ready    = (state == IDLE) ? grant : '0;
  assign busy         = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      rr_ptr         <= ID_W'(NUM_REQ-1);
      resp_valid     <= 1'b0;
      resp_id        <= '0;
      resp_quotient  <= '0;
      resp_remainder <= '0;
      resp_error     <= 1'b0;
      div_start      <= 1'b0;
      div_dividend   <= '0;
      div_divisor    <= '0;
`ifdef DIV_TIMEOUT_EN
      wd_cnt         <= '0;
`endif
    end else begin
      div_start <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_valid) begin
            rr_ptr       <= grant_idx;
            resp_id      <= grant_idx;
            div_dividend <= sel_dividend;
            div_divisor  <= sel_divisor;
            // Divide-by-zero never reaches the divider.
            if (sel_divisor == '0) begin
              resp_quotient  <= '1;
              resp_remainder <= sel_dividend;
              resp_error     <= 1'b1;
              resp_valid     <= 1'b1;
              state          <= RESP;
            end else begin
              div_start <= 1'b1;
              state     <= ISSUE;
            end
          end
        end
        ISSUE: begin
`ifdef DIV_TIMEOUT_EN
          wd_cnt <= '0;
`endif
          state <= ARM;
        end
        ARM: begin
`ifdef DIV_TIMEOUT_EN
          wd_cnt <= wd_cnt + 1'b1;
`endif
          state <= WAIT;
        end
        WAIT: begin
          if (div_done) begin
            resp_quotient  <= div_quotient;
            resp_remainder <= div_remainder;
            resp_error     <= div_error;
            resp_valid     <= 1'b1;
            state          <= RESP;
          end
`ifdef DIV_TIMEOUT_EN
          else if (wd_cnt == CNT_W'(TIMEOUT)) begin
            resp_quotient  <= '0;
            resp_remainder <= '0;
            resp_error     <= 1'b1;
            resp_valid     <= 1'b1;
            state          <= RESP;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
`endif
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_arbiter.sv
// Directed bench for divider_arbiter with a behavioural 6-cycle divider model.
module tb_divider_arbiter;

  localparam int WIDTH   = 32;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int LAT     = 6;

  logic                     clk = 1'b0;
  logic                     reset = 1'b0;
  logic [NUM_REQ-1:0]       req_valid = '0;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_dividend = '0;
  logic [NUM_REQ*WIDTH-1:0] req_divisor = '0;
  logic                     resp_valid;
  logic                     resp_ready = 1'b0;
  logic [ID_W-1:0]          resp_id;
  logic [WIDTH-1:0]         resp_quotient;
  logic [WIDTH-1:0]         resp_remainder;
  logic                     resp_error;
  logic                     div_start;
  logic [WIDTH-1:0]         div_dividend;
  logic [WIDTH-1:0]         div_divisor;
  logic [WIDTH-1:0]         div_quotient = '0;
  logic [WIDTH-1:0]         div_remainder = '0;
  logic                     div_error = 1'b0;
  logic                     div_done = 1'b0;
  logic                     busy;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  int model_cnt = 0;
  logic div_hold = 1'b0;
  logic [WIDTH-1:0] model_a = '0;
  logic [WIDTH-1:0] model_b = '0;

  always #5 clk = ~clk;

  divider_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .TIMEOUT(20)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_dividend   (req_dividend),
    .req_divisor    (req_divisor),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_id        (resp_id),
    .resp_quotient  (resp_quotient),
    .resp_remainder (resp_remainder),
    .resp_error     (resp_error),
    .div_start      (div_start),
    .div_dividend   (div_dividend),
    .div_divisor    (div_divisor),
    .div_quotient   (div_quotient),
    .div_remainder  (div_remainder),
    .div_error      (div_error),
    .div_done       (div_done),
    .busy           (busy)
  );

  // Divider model: done is a level that rises LAT edges after start and drops on the next start.
  always @(posedge clk) begin
    if (div_start) begin
      start_cnt <= start_cnt + 1;
      model_a   <= div_dividend;
      model_b   <= div_divisor;
      model_cnt <= LAT;
      div_done  <= 1'b0;
    end else if (model_cnt == 1) begin
      model_cnt <= 0;
      if (!div_hold) begin
        div_done      <= 1'b1;
        div_quotient  <= model_a / model_b;
        div_remainder <= model_a % model_b;
        div_error     <= 1'b0;
      end
    end else if (model_cnt > 1) begin
      model_cnt <= model_cnt - 1;
    end
  end

  task automatic set_req(input int id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    req_dividend[id*WIDTH +: WIDTH] = a;
    req_divisor[id*WIDTH +: WIDTH]  = b;
    req_valid[id] = 1'b1;
  endtask

  // Waits (at negedge + 1) for any req_ready; returns cycles waited or -1.
  task automatic wait_grant(output int cyc);
    cyc = -1;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (|req_ready) begin
        cyc = c;
        break;
      end
      @(negedge clk);
    end
    if (cyc < 0) begin
      checks++; errors++;
      $display("[TB] FAIL grant_wait: no req_ready within bound");
    end
  endtask

  task automatic wait_resp(output int cyc);
    cyc = -1;
    for (int c = 1; c < 100; c++) begin
      @(negedge clk);
      if (resp_valid) begin
        cyc = c;
        break;
      end
    end
    if (cyc < 0) begin
      checks++; errors++;
      $display("[TB] FAIL resp_wait: no resp_valid within bound");
    end
  endtask

  task automatic accept_resp();
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({req_ready, resp_valid, resp_id, resp_quotient, resp_remainder, resp_error,
         div_start, div_dividend, div_divisor, busy} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: busy=%b resp_valid=%b q=%0h r=%0h expected all zero",
               busy, resp_valid, resp_quotient, resp_remainder);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || req_ready !== '0) begin
      errors++;
      $display("[TB] FAIL reset_idle: busy=%b req_ready=%b expected 0/0000", busy, req_ready);
    end
  endtask

  task automatic test_single();
    int g, lat, s0;
    s0 = start_cnt;
    set_req(0, 45234, 101);
    wait_grant(g);
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL single_grant: req_ready=%b expected 0001", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    checks++;
    if (div_start !== 1'b1 || div_dividend !== 45234 || div_divisor !== 101) begin
      errors++;
      $display("[TB] FAIL single_issue: start=%b a=%0d b=%0d expected 1/45234/101",
               div_start, div_dividend, div_divisor);
    end
    wait_resp(lat);
    lat = lat + 1;
    checks++;
    if (lat !== 3 + LAT) begin
      errors++;
      $display("[TB] FAIL single_latency: got %0d cycles expected %0d", lat, 3 + LAT);
    end
    checks++;
    if (resp_id !== 0 || resp_quotient !== 447 || resp_remainder !== 87 || resp_error !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_result: id=%0d q=%0d r=%0d err=%b expected 0/447/87/0",
               resp_id, resp_quotient, resp_remainder, resp_error);
    end
    checks++;
    if (start_cnt - s0 !== 1) begin
      errors++;
      $display("[TB] FAIL single_starts: got %0d pulses expected 1", start_cnt - s0);
    end
    accept_resp();
    checks++;
    if (resp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_release: resp_valid=%b busy=%b expected 0/0", resp_valid, busy);
    end
  endtask

  task automatic test_div_zero();
    int g, s0;
    s0 = start_cnt;
    set_req(2, 1000, 0);
    wait_grant(g);
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++;
      $display("[TB] FAIL dz_grant: req_ready=%b expected 0100", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    checks++;
    if (resp_valid !== 1'b1 || resp_id !== 2 || resp_quotient !== 32'hFFFF_FFFF ||
        resp_remainder !== 1000 || resp_error !== 1'b1) begin
      errors++;
      $display("[TB] FAIL dz_result: v=%b id=%0d q=%0h r=%0d err=%b expected 1/2/ffffffff/1000/1",
               resp_valid, resp_id, resp_quotient, resp_remainder, resp_error);
    end
    accept_resp();
    checks++;
    if (start_cnt - s0 !== 0) begin
      errors++;
      $display("[TB] FAIL dz_no_start: got %0d pulses expected 0", start_cnt - s0);
    end
  endtask

  task automatic test_contention();
    int g, lat;
    int exp_q[4] = '{2, 35, 69, 102};
    int exp_r[4] = '{1, 2, 0, 1};
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) set_req(i, i*100 + 7, 3);
    for (int k = 0; k < NUM_REQ; k++) begin
      wait_grant(g);
      checks++;
      if (req_ready !== NUM_REQ'(1 << k)) begin
        errors++;
        $display("[TB] FAIL cont_grant%0d: req_ready=%b expected %b", k, req_ready, NUM_REQ'(1 << k));
      end
      @(negedge clk);
      req_valid[k] = 1'b0;
      wait_resp(lat);
      checks++;
      if (resp_id !== ID_W'(k) || resp_quotient !== exp_q[k] || resp_remainder !== exp_r[k] ||
          resp_error !== 1'b0) begin
        errors++;
        $display("[TB] FAIL cont_result%0d: id=%0d q=%0d r=%0d err=%b expected %0d/%0d/%0d/0",
                 k, resp_id, resp_quotient, resp_remainder, resp_error, k, exp_q[k], exp_r[k]);
      end
      accept_resp();
    end
    req_valid = '0;
  endtask

  task automatic test_backpressure();
    int g, lat;
    set_req(1, 500, 7);
    wait_grant(g);
    @(negedge clk);
    req_valid = '0;
    wait_resp(lat);
    set_req(3, 81, 9);
    for (int c = 0; c < 10; c++) begin
      #1;
      checks++;
      if (resp_valid !== 1'b1 || resp_id !== 1 || resp_quotient !== 71 || resp_remainder !== 3 ||
          resp_error !== 1'b0 || req_ready !== '0 || busy !== 1'b1) begin
        errors++;
        $display("[TB] FAIL bp_hold%0d: v=%b id=%0d q=%0d r=%0d rdy=%b busy=%b expected 1/1/71/3/0000/1",
                 c, resp_valid, resp_id, resp_quotient, resp_remainder, req_ready, busy);
      end
      @(negedge clk);
    end
    accept_resp();
    wait_grant(g);
    checks++;
    if (req_ready !== 4'b1000) begin
      errors++;
      $display("[TB] FAIL bp_next_grant: req_ready=%b expected 1000", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    wait_resp(lat);
    checks++;
    if (resp_id !== 3 || resp_quotient !== 9 || resp_remainder !== 0) begin
      errors++;
      $display("[TB] FAIL bp_next_result: id=%0d q=%0d r=%0d expected 3/9/0",
               resp_id, resp_quotient, resp_remainder);
    end
    accept_resp();
  endtask

  task automatic test_reset_mid();
    int g, lat;
    set_req(0, 45234, 101);
    wait_grant(g);
    @(negedge clk);
    req_valid = '0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if ({req_ready, resp_valid, resp_id, resp_quotient, resp_remainder, resp_error,
         div_start, div_dividend, div_divisor, busy} !== '0) begin
      errors++;
      $display("[TB] FAIL midreset_outputs: busy=%b a=%0d b=%0d expected all zero",
               busy, div_dividend, div_divisor);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    set_req(0, 45234, 101);
    wait_grant(g);
    @(negedge clk);
    req_valid = '0;
    wait_resp(lat);
    checks++;
    if (resp_id !== 0 || resp_quotient !== 447 || resp_remainder !== 87 || resp_error !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_result: id=%0d q=%0d r=%0d err=%b expected 0/447/87/0",
               resp_id, resp_quotient, resp_remainder, resp_error);
    end
    accept_resp();
  endtask

`ifdef DIV_TIMEOUT_EN
  task automatic test_timeout();
    int g, lat;
    div_hold = 1'b1;
    set_req(1, 900, 4);
    wait_grant(g);
    @(negedge clk);
    req_valid = '0;
    wait_resp(lat);
    checks++;
    if (lat !== 22) begin
      errors++;
      $display("[TB] FAIL timeout_latency: got %0d cycles after ISSUE expected 22", lat);
    end
    checks++;
    if (resp_error !== 1'b1 || resp_quotient !== 0 || resp_remainder !== 0) begin
      errors++;
      $display("[TB] FAIL timeout_result: err=%b q=%0d r=%0d expected 1/0/0",
               resp_error, resp_quotient, resp_remainder);
    end
    accept_resp();
    div_hold = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_div_zero();
    test_contention();
    test_backpressure();
    test_reset_mid();
`ifdef DIV_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
